// File: rtl/sdram_wb_prefetch.sv
// Wishbone slave front-end for the SDRAM controller with a DEPTH-word prefetch line.
// Define SDRAM_PREFETCH_STATS_EN to add Wishbone-readable hit/miss counters.
module sdram_wb_prefetch #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  output logic              ctrl_rw,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_data_in,
  output logic [3:0]        ctrl_mask,
  input  logic [DATA_W-1:0] ctrl_data_out,
  input  logic              ctrl_out_valid
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_ACK_GAP
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   fill_ptr_q, fill_ptr_n;
  logic [IDX_W-1:0]   req_idx_q, req_idx_n;
  logic [TAG_W-1:0]   tag_q, tag_n;
  logic               line_valid_q, line_valid_n;
  logic [DEPTH-1:0]   word_valid_q, word_valid_n;
  logic               pend_q, pend_n;
  logic [DATA_W-1:0]  line_buf [DEPTH];

  logic               ack_n;
  logic [DATA_W-1:0]  dat_n;
  logic               in_valid_n, rw_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DATA_W-1:0]  data_in_n;
  logic [3:0]         mask_n;

  logic               buf_we;
  logic [IDX_W-1:0]   buf_widx;
  logic [DATA_W-1:0]  buf_wdata;
  logic [DATA_W-1:0]  merged;

  logic               req, tag_hit, rd_hit;
  logic [TAG_W-1:0]   adr_tag;
  logic [IDX_W-1:0]   adr_idx;
  logic               unused_adr;

  assign req        = wbs_stb_i & wbs_cyc_i;
  assign adr_tag    = wbs_adr_i[ADDR_W-1:OFF_W];
  assign adr_idx    = wbs_adr_i[OFF_W-1:2];
  assign tag_hit    = (adr_tag == tag_q);
  assign unused_adr = ^{wbs_adr_i[1:0], wbs_adr_i >> ADDR_W};

`ifdef SDRAM_PREFETCH_STATS_EN
  localparam logic [ADDR_W-1:0] STAT_HIT_ADR  = ADDR_W'(32'h7FFFF8);
  localparam logic [ADDR_W-1:0] STAT_MISS_ADR = ADDR_W'(32'h7FFFFC);

  logic [31:0] hit_cnt, miss_cnt;
  logic        stat_sel, stat_clr, hit_ev, miss_ev;

  assign stat_sel = (wbs_adr_i[ADDR_W-1:2] == STAT_HIT_ADR[ADDR_W-1:2]) ||
                    (wbs_adr_i[ADDR_W-1:2] == STAT_MISS_ADR[ADDR_W-1:2]);
  assign stat_clr = (state_q == S_IDLE) && req && !wbs_ack_o && wbs_we_i && stat_sel;
  assign miss_ev  = (state_q == S_IDLE) && (state_n == S_FILL_REQ);
  // pend_q marks an ack that completes a miss, so it is not counted as a hit
  assign hit_ev   = ack_n && !wbs_we_i && !stat_sel && !pend_q;
  assign rd_hit   = req && !wbs_we_i && !stat_sel && tag_hit && word_valid_q[adr_idx] && !wbs_ack_o;
`else
  assign rd_hit   = req && !wbs_we_i && tag_hit && word_valid_q[adr_idx] && !wbs_ack_o;
`endif

  // Byte-lane merge of the write data into the currently buffered word
  always_comb begin
    merged = line_buf[adr_idx];
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state_q;
    fill_ptr_n   = fill_ptr_q;
    req_idx_n    = req_idx_q;
    tag_n        = tag_q;
    line_valid_n = line_valid_q;
    word_valid_n = word_valid_q;
    pend_n       = pend_q;
    ack_n        = 1'b0;
    dat_n        = wbs_dat_o;
    in_valid_n   = ctrl_in_valid;
    rw_n         = ctrl_rw;
    addr_n       = ctrl_addr;
    data_in_n    = ctrl_data_in;
    mask_n       = ctrl_mask;
    buf_we       = 1'b0;
    buf_widx     = fill_ptr_q;
    buf_wdata    = ctrl_data_out;

    unique case (state_q)
      S_IDLE: begin
        // A request seen while its ack is still high is the same strobe; skip it
        if (req && !wbs_ack_o) begin
`ifdef SDRAM_PREFETCH_STATS_EN
          if (stat_sel) begin
            ack_n = 1'b1;
            if (!wbs_we_i) dat_n = wbs_adr_i[2] ? miss_cnt : hit_cnt;
          end else
`endif
          if (wbs_we_i) begin
            in_valid_n = 1'b1;
            rw_n       = 1'b1;
            mask_n     = wbs_sel_i;
            data_in_n  = wbs_dat_i;
            addr_n     = {wbs_adr_i[ADDR_W-1:2], 2'b00};
            state_n    = S_WR_REQ;
          end else if (line_valid_q && tag_hit) begin
            ack_n = 1'b1;
            dat_n = line_buf[adr_idx];
          end else begin
            tag_n        = adr_tag;
            line_valid_n = 1'b0;
            word_valid_n = '0;
            fill_ptr_n   = '0;
            req_idx_n    = adr_idx;
            pend_n       = 1'b1;
            in_valid_n   = 1'b1;
            rw_n         = 1'b0;
            mask_n       = 4'b0000;
            addr_n       = {adr_tag, IDX_W'(0), 2'b00};
            state_n      = S_FILL_REQ;
          end
        end
      end

      S_WR_REQ: begin
        if (ctrl_in_valid && !ctrl_busy) begin
          in_valid_n = 1'b0;
          ack_n      = 1'b1;
          state_n    = S_ACK_GAP;
          if (line_valid_q && tag_hit) begin
            buf_we    = 1'b1;
            buf_widx  = adr_idx;
            buf_wdata = merged;
          end
        end
      end

      S_FILL_REQ, S_FILL_WAIT: begin
        if (pend_q && !req) pend_n = 1'b0;
        if (!pend_q && rd_hit) begin
          ack_n = 1'b1;
          dat_n = line_buf[adr_idx];
        end
        if (state_q == S_FILL_REQ) begin
          if (ctrl_in_valid && !ctrl_busy) begin
            in_valid_n = 1'b0;
            state_n    = S_FILL_WAIT;
          end
        end else if (ctrl_out_valid) begin
          buf_we                   = 1'b1;
          word_valid_n[fill_ptr_q] = 1'b1;
          if (pend_q && req && (fill_ptr_q == req_idx_q)) begin
            ack_n  = 1'b1;
            dat_n  = ctrl_data_out;
            pend_n = 1'b0;
          end
          if (fill_ptr_q == IDX_W'(DEPTH - 1)) begin
            line_valid_n = 1'b1;
            pend_n       = 1'b0;
            state_n      = S_IDLE;
          end else begin
            fill_ptr_n = fill_ptr_q + IDX_W'(1);
            in_valid_n = 1'b1;
            addr_n     = {tag_q, fill_ptr_n, 2'b00};
            state_n    = S_FILL_REQ;
          end
        end
      end

      S_ACK_GAP: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fill_ptr_q    <= '0;
      req_idx_q     <= '0;
      tag_q         <= '0;
      line_valid_q  <= 1'b0;
      word_valid_q  <= '0;
      pend_q        <= 1'b0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      ctrl_in_valid <= 1'b0;
      ctrl_rw       <= 1'b0;
      ctrl_addr     <= '0;
      ctrl_data_in  <= '0;
      ctrl_mask     <= '0;
    end else begin
      state_q       <= state_n;
      fill_ptr_q    <= fill_ptr_n;
      req_idx_q     <= req_idx_n;
      tag_q         <= tag_n;
      line_valid_q  <= line_valid_n;
      word_valid_q  <= word_valid_n;
      pend_q        <= pend_n;
      wbs_ack_o     <= ack_n;
      wbs_dat_o     <= dat_n;
      ctrl_in_valid <= in_valid_n;
      ctrl_rw       <= rw_n;
      ctrl_addr     <= addr_n;
      ctrl_data_in  <= data_in_n;
      ctrl_mask     <= mask_n;
    end
  end

  // Line storage; contents are qualified by word_valid, so no reset is needed
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[buf_widx] <= buf_wdata;
  end

`ifdef SDRAM_PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (stat_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_ev && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_ev && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_wb_prefetch.sv
// Directed bench for sdram_wb_prefetch with a small SDRAM controller model.
module tb_sdram_wb_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ctrl_in_valid, ctrl_busy, ctrl_rw;
  logic [22:0] ctrl_addr;
  logic [31:0] ctrl_data_in;
  logic [3:0]  ctrl_mask;
  logic [31:0] ctrl_data_out = 32'h0;
  logic        ctrl_out_valid = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_wb_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy), .ctrl_rw(ctrl_rw),
    .ctrl_addr(ctrl_addr), .ctrl_data_in(ctrl_data_in), .ctrl_mask(ctrl_mask),
    .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid)
  );

  // SDRAM controller model: word i preloads to 0xA0+i, reads return 2 cycles after acceptance
  logic [31:0] mem [0:255];
  logic        preloaded = 1'b0;
  int          acc_cnt = 0;
  int          ov_cnt  = 0;
  int          rd_cnt  = 0;
  logic [22:0] rd_addr;
  logic [22:0] log_addr [0:127];
  logic        log_rw   [0:127];
  logic [3:0]  log_mask [0:127];
  logic [31:0] log_data [0:127];

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + 32'(i);
      preloaded = 1'b1;
    end
    ctrl_out_valid <= 1'b0;
    if (rd_cnt == 1) begin
      ctrl_out_valid <= 1'b1;
      ctrl_data_out  <= mem[rd_addr[9:2]];
      ov_cnt++;
    end
    if (rd_cnt != 0) rd_cnt--;
    if (ctrl_in_valid && !ctrl_busy) begin
      log_addr[acc_cnt % 128] = ctrl_addr;
      log_rw[acc_cnt % 128]   = ctrl_rw;
      log_mask[acc_cnt % 128] = ctrl_mask;
      log_data[acc_cnt % 128] = ctrl_data_in;
      if (ctrl_rw) begin
        for (int b = 0; b < 4; b++)
          if (ctrl_mask[b]) mem[ctrl_addr[9:2]][8*b +: 8] = ctrl_data_in[8*b +: 8];
      end else begin
        rd_cnt  = 2;
        rd_addr = ctrl_addr;
      end
      acc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
  endtask

  // Waits (bounded) for ack, holds stb through the ack cycle and checks it is not re-acked
  task automatic wb_wait(input string tag, output logic [31:0] d, output int lat,
                         output int ov_at_ack);
    lat = 0;
    do begin tick(); lat++; end while (!wbs_ack_o && lat < 100);
    check({tag, "_ack"}, 32'(wbs_ack_o), 32'd1);
    d = wbs_dat_o;
    ov_at_ack = ov_cnt;
    tick();
    check({tag, "_single_ack"}, 32'(wbs_ack_o), 32'd0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wait_ov(input string tag, input int target);
    for (int i = 0; i < 300 && ov_cnt < target; i++) tick();
    check({tag, "_fill_done"}, 32'(ov_cnt), 32'(target));
    tick(); tick();
  endtask

  task automatic check_fill(input string tag, input int base, input int line);
    for (int i = 0; i < 8; i++)
      check(tag, 32'({log_rw[(base + i) % 128], log_mask[(base + i) % 128], log_addr[(base + i) % 128]}),
            32'({1'b0, 4'b0000, 23'(line + 4 * i)}));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"},  32'(wbs_ack_o), 32'd0);
    check({tag, "_dat"},  wbs_dat_o, 32'd0);
    check({tag, "_civ"},  32'(ctrl_in_valid), 32'd0);
    check({tag, "_rw"},   32'(ctrl_rw), 32'd0);
    check({tag, "_addr"}, 32'(ctrl_addr), 32'd0);
    check({tag, "_din"},  ctrl_data_in, 32'd0);
    check({tag, "_mask"}, 32'(ctrl_mask), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int lat, ova, ab, ob, n_ack;

    rst_n = 1'b0; ctrl_busy = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    tick(); tick();
    check_reset("por");
    rst_n = 1'b1;
    tick(); tick();

    // Cold read of 0x08: full fill from 0x00, early ack after the third return
    ab = acc_cnt; ob = ov_cnt;
    wb_start(1'b0, 32'h08, 4'hF, 32'h0);
    wb_wait("cold", d, lat, ova);
    check("cold_data", d, 32'hA2);
    check("cold_ack_after_3rd", 32'(ova - ob), 32'd3);
    wait_ov("cold", ob + 8);
    check("cold_nreq", 32'(acc_cnt - ab), 32'd8);
    check_fill("cold_fill", ab, 32'h00);

    // Sequential hits: latency 1, no controller traffic
    ab = acc_cnt;
    wb_start(1'b0, 32'h0C, 4'hF, 32'h0);
    wb_wait("hit0c", d, lat, ova);
    check("hit0c_data", d, 32'hA3);
    check("hit0c_lat", 32'(lat), 32'd1);
    wb_start(1'b0, 32'h1C, 4'hF, 32'h0);
    wb_wait("hit1c", d, lat, ova);
    check("hit1c_data", d, 32'hA7);
    check("hit1c_lat", 32'(lat), 32'd1);
    check("hits_nreq", 32'(acc_cnt - ab), 32'd0);

    // Write-hit merge, low and high byte lanes
    ab = acc_cnt;
    wb_start(1'b1, 32'h04, 4'b0011, 32'h1234_5678);
    wb_wait("wr04", d, lat, ova);
    check("wr04_nreq", 32'(acc_cnt - ab), 32'd1);
    check("wr04_req", 32'({log_rw[ab % 128], log_mask[ab % 128], log_addr[ab % 128]}),
          32'({1'b1, 4'b0011, 23'h04}));
    check("wr04_wdata", log_data[ab % 128], 32'h1234_5678);
    wb_start(1'b0, 32'h04, 4'hF, 32'h0);
    wb_wait("rd04", d, lat, ova);
    check("rd04_data", d, 32'h0000_5678);
    check("rd04_lat", 32'(lat), 32'd1);
    wb_start(1'b1, 32'h08, 4'b1100, 32'hCAFE_1234);
    wb_wait("wr08", d, lat, ova);
    check("wr08_mask", 32'(log_mask[(ab + 1) % 128]), 32'b1100);
    wb_start(1'b0, 32'h08, 4'hF, 32'h0);
    wb_wait("rd08", d, lat, ova);
    check("rd08_data", d, 32'hCAFE_00A2);
    check("wr_nreq", 32'(acc_cnt - ab), 32'd2);

    // Line replace: 0x20 misses, then 0x00 misses again
    ab = acc_cnt; ob = ov_cnt;
    wb_start(1'b0, 32'h20, 4'hF, 32'h0);
    wb_wait("rd20", d, lat, ova);
    check("rd20_data", d, 32'hA8);
    wait_ov("rd20", ob + 8);
    check_fill("rd20_fill", ab, 32'h20);
    ab = acc_cnt; ob = ov_cnt;
    wb_start(1'b0, 32'h00, 4'hF, 32'h0);
    wb_wait("rd00", d, lat, ova);
    check("rd00_data", d, 32'hA0);
    check("rd00_lat", 32'(lat), 32'd5);
    wait_ov("rd00", ob + 8);
    check("rd00_nreq", 32'(acc_cnt - ab), 32'd8);
    wb_start(1'b0, 32'h08, 4'hF, 32'h0);
    wb_wait("refill08", d, lat, ova);
    check("refill08_data", d, 32'hCAFE_00A2);

    // Busy backpressure: request held stable, no ack while busy
    ab = acc_cnt; ob = ov_cnt;
    ctrl_busy = 1'b1;
    wb_start(1'b0, 32'h40, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_civ", 32'(ctrl_in_valid), 32'd1);
      check("busy_addr", 32'(ctrl_addr), 32'h40);
      check("busy_ack", 32'(wbs_ack_o), 32'd0);
    end
    ctrl_busy = 1'b0;
    wb_wait("busy", d, lat, ova);
    check("busy_data", d, 32'hB0);
    check("busy_lat", 32'(lat), 32'd4);
    wait_ov("busy", ob + 8);
    check("busy_nreq", 32'(acc_cnt - ab), 32'd8);
    check_fill("busy_fill", ab, 32'h40);

    // Master abort mid-fill: fill completes, no ack
    ob = ov_cnt; n_ack = 0;
    wb_start(1'b0, 32'h88, 4'hF, 32'h0);
    for (int i = 0; i < 100 && ov_cnt < ob + 1; i++) tick();
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    for (int i = 0; i < 100 && ov_cnt < ob + 8; i++) begin
      tick();
      n_ack += int'(wbs_ack_o);
    end
    tick(); n_ack += int'(wbs_ack_o);
    tick(); n_ack += int'(wbs_ack_o);
    check("abort_no_ack", 32'(n_ack), 32'd0);
    wb_start(1'b0, 32'h88, 4'hF, 32'h0);
    wb_wait("abort_rd88", d, lat, ova);
    check("abort_rd88_data", d, 32'hC2);
    check("abort_rd88_lat", 32'(lat), 32'd1);

    // Requests during a fill: valid word hits, invalid word stalls to fill end
    ob = ov_cnt;
    wb_start(1'b0, 32'hC4, 4'hF, 32'h0);
    wb_wait("rdc4", d, lat, ova);
    check("rdc4_data", d, 32'hD1);
    wb_start(1'b0, 32'hC0, 4'hF, 32'h0);
    wb_wait("fillhit", d, lat, ova);
    check("fillhit_data", d, 32'hD0);
    check("fillhit_lat", 32'(lat), 32'd1);
    wb_start(1'b0, 32'hDC, 4'hF, 32'h0);
    wb_wait("stall", d, lat, ova);
    check("stall_data", d, 32'hD7);
    check("stall_after_fill", 32'(ova - ob), 32'd8);
    wait_ov("stall", ob + 8);

    // Reset mid-fill, then a fresh full fill
    ob = ov_cnt;
    wb_start(1'b0, 32'h60, 4'hF, 32'h0);
    for (int i = 0; i < 100 && ov_cnt < ob + 2; i++) tick();
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_reset("post_rst");
    ab = acc_cnt; ob = ov_cnt;
    wb_start(1'b0, 32'h10, 4'hF, 32'h0);
    wb_wait("rst_rd10", d, lat, ova);
    check("rst_rd10_data", d, 32'hA4);
    check("rst_rd10_ack_after_5th", 32'(ova - ob), 32'd5);
    wait_ov("rst_rd10", ob + 8);
    check("rst_rd10_nreq", 32'(acc_cnt - ab), 32'd8);
    check_fill("rst_fill", ab, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_wb_prefetch.md
Name: sdram_wb_prefetch

Overview:
- Wishbone slave front-end between the management-SoC Wishbone port and the SDRAM controller's user request interface.
- Converts Wishbone cycles into single-outstanding controller requests.
- Holds one prefetch line of DEPTH consecutive words, so sequential reads (instruction fetch, memcpy) hit in one cycle instead of paying a full SDRAM access.
- Writes pass through to SDRAM and update the line in place when they hit it.

Parameters:
- ADDR_W, 23: controller byte-address width; wbs_adr_i[ADDR_W-1:0] is used, upper bits ignored.
- DATA_W, 32: data width; fixed at 32, since byte lanes are 4.
- DEPTH, 8: words per prefetch line; power of 2, range 2..16.

Ports:
- clk  in  1  block clock, shared with the SDRAM controller
- rst_n  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address; bits [1:0] ignored
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- ctrl_in_valid  out  1  request valid to controller
- ctrl_busy  in  1  controller cannot accept a request
- ctrl_rw  out  1  1 = write
- ctrl_addr  out  ADDR_W  word-aligned byte address
- ctrl_data_in  out  32  write data
- ctrl_mask  out  4  write byte mask; 0 for reads
- ctrl_data_out  in  32  read data
- ctrl_out_valid  in  1  one-cycle pulse; ctrl_data_out valid

Behaviour:
- Reset values (async on rst_n low): state=IDLE, wbs_ack_o=0, wbs_dat_o=0, ctrl_in_valid=0, ctrl_rw=0, ctrl_addr=0, ctrl_data_in=0, ctrl_mask=0, line_valid=0, all word_valid=0.
- Request: req = wbs_stb_i & wbs_cyc_i.
- Address split: word index = adr[log2(DEPTH)+1:2]; tag = adr[ADDR_W-1:log2(DEPTH)+2].
- Hit: req & !we & line_valid & tag match & word_valid[idx].

Controller handshake:
- Request accepted on the cycle ctrl_in_valid & !ctrl_busy.
- After acceptance, ctrl_in_valid drops the next cycle.
- At most one read outstanding; the next request is not issued until ctrl_out_valid.
- Address, data and mask are held stable while ctrl_in_valid is high.

States:
- IDLE
  - Hit: wbs_ack_o=1 and wbs_dat_o=buf[idx] on the next cycle (latency 1). Stay in IDLE.
  - Read miss: latch tag, clear line_valid and word_valid, set fill_ptr=0, save the requested idx. Go to FILL_REQ.
  - Write: drive ctrl_rw=1, ctrl_mask=wbs_sel_i. Go to WR_REQ.
- WR_REQ
  - Hold ctrl_in_valid until accepted.
  - On acceptance: pulse wbs_ack_o; if tag matches a valid line, byte-merge wbs_dat_i into buf[idx] per wbs_sel_i. Go to ACK_GAP.
- FILL_REQ
  - Issue a read at {tag, fill_ptr, 2'b00}.
  - On acceptance, go to FILL_WAIT.
- FILL_WAIT
  - On ctrl_out_valid: buf[fill_ptr] <= ctrl_data_out; word_valid[fill_ptr] <= 1.
  - If fill_ptr == requested idx, pulse wbs_ack_o with that data (early ack; the fill continues).
  - If fill_ptr == DEPTH-1: set line_valid=1, go to IDLE.
  - Otherwise fill_ptr++ and go to FILL_REQ.
- Requests arriving during a fill:
  - A read hitting an already-valid word is acked (latency 1).
  - All other requests stall (no ack) until the fill completes.
- ACK_GAP: one idle cycle so the same stb is not double-acked. Return to IDLE.

Other rules:
- wbs_ack_o is never high two consecutive cycles for one request.
- req deasserted mid-fill (master abort): the fill completes; no ack is issued after the abort.
- fill_ptr wraps at DEPTH. A line never crosses its DEPTH*4-byte aligned boundary.
- ctrl_out_valid outside FILL_WAIT is ignored.

Optional Feature:
- Macro: SDRAM_PREFETCH_STATS_EN.
- Enabled:
  - Two 32-bit saturating counters, hit_cnt and miss_cnt, reset to 0.
  - Readable through Wishbone at byte addresses ADDR_W'h7FFFF8 (hits) and ADDR_W'h7FFFFC (misses), ack latency 1, never forwarded to the controller.
  - A write of any value to either address clears both counters.
- Disabled: counters absent; those addresses are ordinary SDRAM addresses.

Test Plan:
- Reset: rst_n low mid-fill, released -> all outputs 0, state IDLE; a read of 0x10 then performs a full fresh 8-word fill.
- Cold read: preload SDRAM words 0x00..0x1C = 0xA0..0xA7, read 0x08 -> 8 controller reads at 0x00,0x04..0x1C; ack with 0xA2 after the 3rd out_valid.
- Sequential hits: after the fill, read 0x0C, 0x1C -> each acked 1 cycle after stb with 0xA3, 0xA7; zero ctrl_in_valid pulses.
- Write hit merge: write 0x04 sel=4'b0011 data=0x1234_5678 -> one ctrl write, mask 4'b0011; a subsequent read of 0x04 hits and returns 0x0000_5678 merged with the upper bytes of 0xA1.
- Line replace: read 0x20 after the above -> miss, 8 reads at 0x20..0x3C; a later read of 0x00 misses again.
- Busy backpressure: hold ctrl_busy=1 for 5 cycles during FILL_REQ -> ctrl_in_valid stays high with stable ctrl_addr; no ack until data returns.
